// File: rtl/data_memory.sv
// Word-organised single-port data memory for the CPU memory stage: async-cleared array,
// synchronous write, combinational read (registered read when DATA_MEMORY_REG_READ_EN is defined).
module data_memory #(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned DATA_WIDTH  = 32,
  localparam int unsigned INDEX_WIDTH = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           address,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [INDEX_WIDTH-1:0] index_c;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0]  rd_word_c;
  logic                   unused_addr_c;

  // Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS.
  assign index_c       = address[INDEX_WIDTH-1:0];
  assign unused_addr_c = ^address[31:INDEX_WIDTH];

  // Storage array: reset clears every word, write lands on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemWrite) begin
      mem_q[index_c] <= write_data;
    end
  end

  // Array is all-zero during reset, so the read needs no extra reset gating.
  assign rd_word_c = MemRead ? mem_q[index_c] : '0;

`ifdef DATA_MEMORY_REG_READ_EN
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;

  // Sampled alongside the write, so read-during-write returns the old word.
  assign rd_d = rd_word_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign read_data = rd_q;
`else
  assign read_data = rd_word_c;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expectations follow DATA_MEMORY_REG_READ_EN.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int n_vec;
  int n_err;

  data_memory #(.DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    n_vec++;
    assert (read_data === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, read_data, exp);
      end
  endtask

  // Let a newly applied read settle: one edge of latency in registered mode.
  task automatic settle();
`ifdef DATA_MEMORY_REG_READ_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite   = we;
    MemRead    = re;
    address    = a;
    write_data = d;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    address    = 32'd5;
    MemWrite   = 1'b0;
    MemRead    = 1'b1;
    write_data = 32'h0;
    #1;
    check("in_reset_read", 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cleared array reads zero, including both ends of the index range.
    drive(1'b0, 1'b1, 32'd5, 32'h0);   settle(); check("post_reset_a5", 32'h0);
    drive(1'b0, 1'b1, 32'd0, 32'h0);   settle(); check("post_reset_a0", 32'h0);
    drive(1'b0, 1'b1, 32'd255, 32'h0); settle(); check("post_reset_a255", 32'h0);

    write_word(32'd10, 32'd13);
    drive(1'b0, 1'b1, 32'd10, 32'h0);  settle(); check("read_a10", 32'd13);
    drive(1'b0, 1'b0, 32'd10, 32'h0);  settle(); check("read_disabled", 32'h0);
    drive(1'b0, 1'b1, 32'd266, 32'h0); settle(); check("wrap_a266", 32'd13);

    write_word(32'd255, 32'hA5A5_5A5A);
    drive(1'b0, 1'b1, 32'd511, 32'h0); settle(); check("wrap_a511", 32'hA5A5_5A5A);

    // Neither enable: storage holds and output is zero.
    write_word(32'd20, 32'd55);
    drive(1'b0, 1'b0, 32'd20, 32'h0);  settle(); check("idle_zero", 32'h0);
    drive(1'b0, 1'b1, 32'd20, 32'h0);  settle(); check("idle_held", 32'd55);

    // Read-during-write to the same index.
    drive(1'b1, 1'b1, 32'd7, 32'hDEAD_BEEF);
`ifdef DATA_MEMORY_REG_READ_EN
    @(posedge clk); #1;
    check("rdw_old", 32'h0);
    MemWrite = 1'b0;
    @(posedge clk); #1;
    check("rdw_new", 32'hDEAD_BEEF);
`else
    #1;
    check("rdw_before_edge", 32'h0);
    @(posedge clk); #1;
    check("rdw_after_edge", 32'hDEAD_BEEF);
    MemWrite = 1'b0;
`endif

    // Reset pulse between edges clears storage without a clock edge.
    write_word(32'd3, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 32'd3, 32'h0);   settle(); check("a3_stored", 32'hFFFF_FFFF);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_pulse_immediate", 32'h0);
    #1 rst_n = 1'b1;
    #1 check("after_pulse_a3", 32'h0);
    settle(); check("after_pulse_a3_settled", 32'h0);
    drive(1'b0, 1'b1, 32'd7, 32'h0);   settle(); check("after_pulse_a7", 32'h0);

    // Writes are blocked while reset is held.
    @(negedge clk);
    rst_n      = 1'b0;
    MemWrite   = 1'b1;
    MemRead    = 1'b1;
    address    = 32'd4;
    write_data = 32'd99;
    repeat (3) @(posedge clk);
    #1 check("held_reset_read", 32'h0);
    @(negedge clk);
    MemWrite = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 1'b1, 32'd4, 32'h0);   settle(); check("held_reset_a4", 32'h0);
    drive(1'b0, 1'b1, 32'd10, 32'h0);  settle(); check("held_reset_a10", 32'h0);

    write_word(32'd4, 32'h1234_5678);
    drive(1'b0, 1'b1, 32'd4, 32'h0);   settle(); check("post_reset_write", 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
